store_unit: RTL and testbench

- Store-side memory interface for the RV32I datapath.
- Accepts one store request per transaction from the execute stage.
- Steers the data onto byte lanes with write strobes, and drives a valid/ready write to data memory.
- Write-direction counterpart of the load-side word select and extend path; reports completion, misalignment and memory timeout.

---
 rtl/store_unit.sv | 134 +++++++++++++
 tb/tb_store_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Store-side memory interface: steers rs2 onto byte lanes with write strobes
// and performs a valid/ready write to data memory with a bounded wait.
module store_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      funct3,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    output logic            done,
    output logic            misaligned,
    output logic            timeout,
    output logic            busy
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            legal;
    logic [3:0]      strb_n;
    logic [XLEN-1:0] data_n;

    always_comb begin
        legal  = 1'b0;
        strb_n = '0;
        data_n = '0;
        case (funct3)
            3'b000: begin
                legal  = 1'b1;
                strb_n = 4'b0001 << addr[1:0];
                data_n = {4{wdata[7:0]}};
            end
            3'b001: begin
                legal  = ~addr[0];
                strb_n = addr[1] ? 4'b1100 : 4'b0011;
                data_n = {2{wdata[15:0]}};
            end
            3'b010: begin
                legal  = (addr[1:0] == 2'b00);
                strb_n = 4'b1111;
                data_n = wdata;
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done       <= 1'b0;
                    misaligned <= 1'b0;
                    timeout    <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (legal) begin
                            state     <= ISSUE;
                            mem_valid <= 1'b1;
                            mem_addr  <= {addr[XLEN-1:2], 2'b00};
                            mem_wdata <= data_n;
                            mem_wstrb <= strb_n;
                            cnt       <= '0;
                        end else begin
                            state      <= ERR;
                            misaligned <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // Handshake takes priority over an expiring wait on the same edge.
                    if (mem_ready) begin
                        state     <= DONE;
                        mem_valid <= 1'b0;
                        mem_wstrb <= '0;
                        done      <= 1'b1;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state     <= IDLE;
                        mem_valid <= 1'b0;
                        mem_wstrb <= '0;
                        timeout   <= 1'b1;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                ERR: begin
                    state      <= IDLE;
                    misaligned <= 1'b0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Directed-vector bench for store_unit with hand-computed expectations.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        misaligned;
    logic        timeout;
    logic        busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    store_unit #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .addr      (addr),
        .wdata     (wdata),
        .funct3    (funct3),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .done      (done),
        .misaligned(misaligned),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        @(negedge clk);
        req_valid = 1'b1;
        addr      = a;
        wdata     = d;
        funct3    = f;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_busy"},  {31'd0, busy},      32'd0);
    endtask

    initial begin
        logic [3:0]  exp_strb;
        int unsigned vcnt;
        logic        seen;

        rst_n = 1'b1; req_valid = 1'b0; addr = '0; wdata = '0; funct3 = '0; mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_outs", {25'd0, mem_valid, done, misaligned, timeout, busy, mem_wstrb == 4'd0, 1'b0}, 32'h2);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // SW with memory already ready
        mem_ready = 1'b1;
        issue(32'h1000, 32'hDEADBEEF, 3'b010);
        @(negedge clk);
        check("sw_valid", {31'd0, mem_valid}, 32'd1);
        check("sw_addr",  mem_addr,  32'h1000);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_wstrb", {28'd0, mem_wstrb}, 32'hF);
        check("sw_nodone", {31'd0, done}, 32'd0);
        check("sw_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("sw_done", {31'd0, done}, 32'd1);
        check("sw_valid_off", {31'd0, mem_valid}, 32'd0);
        check("sw_wstrb_off", {28'd0, mem_wstrb}, 32'h0);
        @(negedge clk);
        check("sw_done_off", {31'd0, done}, 32'd0);
        check_idle("sw_idle");

        // SB lane sweep
        for (int i = 0; i < 4; i++) begin
            issue(32'h2000 + i, 32'h000000A5, 3'b000);
            exp_strb = 4'b0001 << i;
            @(negedge clk);
            check("sb_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_strb});
            check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
            check("sb_addr",  mem_addr,  32'h2000);
            @(negedge clk);
            check("sb_done", {31'd0, done}, 32'd1);
            @(negedge clk);
        end

        // SH upper half with a 3-cycle stall
        mem_ready = 1'b0;
        issue(32'h3002, 32'h1234CAFE, 3'b001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sh_valid", {31'd0, mem_valid}, 32'd1);
            check("sh_wdata", mem_wdata, 32'hCAFECAFE);
            check("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
            check("sh_nodone", {31'd0, done}, 32'd0);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("sh_done", {31'd0, done}, 32'd1);
        mem_ready = 1'b0;
        @(negedge clk);
        check_idle("sh_idle");

        // Illegal requests: misaligned SW, misaligned SH, bad funct3
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: issue(32'h4001, 32'h11111111, 3'b010);
                1: issue(32'h4003, 32'h22222222, 3'b001);
                default: issue(32'h4000, 32'h33333333, 3'b011);
            endcase
            @(negedge clk);
            check("mis_pulse", {31'd0, misaligned}, 32'd1);
            check("mis_novalid", {31'd0, mem_valid}, 32'd0);
            check("mis_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            check("mis_clear", {31'd0, misaligned}, 32'd0);
            check("mis_novalid2", {31'd0, mem_valid}, 32'd0);
            check_idle("mis_idle");
        end

        // Timeout with memory never ready
        issue(32'h5000, 32'h0BADF00D, 3'b010);
        vcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_valid) vcnt++;
            if (done) check("to_nodone", {31'd0, done}, 32'd0);
            if (timeout) begin
                seen = 1'b1;
                break;
            end
        end
        check("to_seen", {31'd0, seen}, 32'd1);
        check("to_cycles", vcnt, 32'd16);
        check("to_valid_off", {31'd0, mem_valid}, 32'd0);
        check("to_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        check("to_clear", {31'd0, timeout}, 32'd0);

        // Ready arrives in the last allowed cycle: handshake wins
        issue(32'h5004, 32'h12345678, 3'b010);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("late_valid", {31'd0, mem_valid}, 32'd1);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("late_done", {31'd0, done}, 32'd1);
        check("late_noto", {31'd0, timeout}, 32'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        check("late_noto2", {31'd0, timeout}, 32'd0);

        // Reset in the middle of a stall
        issue(32'h6000, 32'hFEEDFACE, 3'b010);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_valid", {31'd0, mem_valid}, 32'd0);
        check("mrst_addr", mem_addr, 32'h0);
        check("mrst_wdata", mem_wdata, 32'h0);
        check("mrst_wstrb", {28'd0, mem_wstrb}, 32'h0);
        check("mrst_ready", {31'd0, req_ready}, 32'd1);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || timeout || mem_valid) seen = 1'b1;
        end
        check("mrst_quiet", {31'd0, seen}, 32'd0);

        mem_ready = 1'b1;
        issue(32'h7008, 32'hA1B2C3D4, 3'b010);
        @(negedge clk);
        check("post_addr", mem_addr, 32'h7008);
        check("post_wdata", mem_wdata, 32'hA1B2C3D4);
        @(negedge clk);
        check("post_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check_idle("post_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    always @(negedge clk) begin
        if (rst_n && (int'(done) + int'(misaligned) + int'(timeout) > 1))
            check("pulse_mutex", {29'd0, done, misaligned, timeout}, 32'd0);
    end

endmodule
